// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, grant and lamp encodings for the traffic phase scheduler
package traffic_pkg;

    typedef enum logic [3:0] {
        MAIN_GREEN  = 4'd0,
        MAIN_YELLOW = 4'd1,
        ALL_RED_GO  = 4'd2,
        SIDE_GREEN  = 4'd3,
        SIDE_YELLOW = 4'd4,
        PED_WALK    = 4'd5,
        PED_CLEAR   = 4'd6,
        ALL_RED_RET = 4'd7,
        NIGHT_FLASH = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        GRANT_SIDE  = 2'd0,
        GRANT_PED   = 2'd1,
        GRANT_NIGHT = 2'd2
    } grant_t;

    // Lamp words are {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// rtl/traffic_phase_scheduler_tick_gen.sv - free-running prescaler producing a 1-cycle tick
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; the tick is the last count of each period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - main/side/pedestrian intersection phase sequencer
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int T_GREEN_MIN  = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_SIDE_GREEN = 8,
    parameter int T_WALK       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic [3:0] state_o
);

    // Last timer value of each timed phase: the phase ends on the tick seen at this value
    localparam logic [TIMER_W-1:0] GREEN_LAST = TIMER_W'(T_GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(T_YELLOW - 1);
    localparam logic [TIMER_W-1:0] RED_LAST   = TIMER_W'(T_ALL_RED - 1);
    localparam logic [TIMER_W-1:0] SIDE_LAST  = TIMER_W'(T_SIDE_GREEN - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(T_WALK - 1);

    logic               tick;
    state_t             state, state_nx;
    grant_t             grant, grant_nx;
    grant_t             last_served, last_served_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic               flash, flash_nx;
    logic               side_pend, side_pend_nx;
    logic               ped_pend, ped_pend_nx;
    logic [2:0]         main_nx, side_nx;
    logic               walk_nx;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Next state and grant selection; timed phases advance only on a tick at their last count
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            MAIN_GREEN: begin
                if (tick && timer == GREEN_LAST && (night_mode || side_pend || ped_pend)) begin
                    state_nx = MAIN_YELLOW;
                    if (night_mode) begin
                        grant_nx = GRANT_NIGHT;
                    end else if (side_pend && !ped_pend) begin
                        grant_nx = GRANT_SIDE;
                    end else if (!side_pend && ped_pend) begin
                        grant_nx = GRANT_PED;
                    end else begin
                        grant_nx = (last_served == GRANT_SIDE) ? GRANT_PED : GRANT_SIDE;
                    end
                end
            end
            MAIN_YELLOW: if (tick && timer == YEL_LAST) state_nx = ALL_RED_GO;
            ALL_RED_GO: begin
                if (tick && timer == RED_LAST) begin
                    case (grant)
                        GRANT_SIDE: state_nx = SIDE_GREEN;
                        GRANT_PED:  state_nx = PED_WALK;
                        default:    state_nx = NIGHT_FLASH;
                    endcase
                end
            end
            SIDE_GREEN:  if (tick && timer == SIDE_LAST) state_nx = SIDE_YELLOW;
            SIDE_YELLOW: if (tick && timer == YEL_LAST)  state_nx = ALL_RED_RET;
            PED_WALK:    if (tick && timer == WALK_LAST) state_nx = PED_CLEAR;
            PED_CLEAR:   if (tick && timer == YEL_LAST)  state_nx = ALL_RED_RET;
            ALL_RED_RET: if (tick && timer == RED_LAST)  state_nx = MAIN_GREEN;
            NIGHT_FLASH: if (tick && !night_mode)        state_nx = ALL_RED_RET;
            default:     state_nx = MAIN_GREEN;
        endcase
    end

    // Phase timer, flash bit and request latches derived from the chosen next state
    always_comb begin
        timer_nx       = timer;
        flash_nx       = flash;
        side_pend_nx   = side_pend;
        ped_pend_nx    = ped_pend;
        last_served_nx = last_served;

        if (state_nx != state) begin
            timer_nx = '0;
        end else if (tick && !(state == MAIN_GREEN && timer == GREEN_LAST)) begin
            timer_nx = timer + 1'b1;
        end

        if (state_nx != state && (state_nx == NIGHT_FLASH || state_nx == PED_CLEAR)) begin
            flash_nx = 1'b0;
        end else if (tick && (state == NIGHT_FLASH || state == PED_CLEAR)) begin
            flash_nx = ~flash;
        end

        // Requests are ignored while flashing; service entry clears the latch even if still pressed
        if (state != NIGHT_FLASH) begin
            side_pend_nx = side_pend | side_req;
            ped_pend_nx  = ped_pend | ped_req;
        end
        if (state_nx == SIDE_GREEN && state != SIDE_GREEN) begin
            side_pend_nx   = 1'b0;
            last_served_nx = GRANT_SIDE;
        end
        if (state_nx == PED_WALK && state != PED_WALK) begin
            ped_pend_nx    = 1'b0;
            last_served_nx = GRANT_PED;
        end
    end

    // Lamp decode of the next state so the registered lamps track the registered state exactly
    always_comb begin
        main_nx = RED;
        side_nx = RED;
        walk_nx = 1'b0;
        case (state_nx)
            MAIN_GREEN:  main_nx = GRN;
            MAIN_YELLOW: main_nx = YEL;
            SIDE_GREEN:  side_nx = GRN;
            SIDE_YELLOW: side_nx = YEL;
            PED_WALK:    walk_nx = 1'b1;
            PED_CLEAR:   walk_nx = flash_nx;
            NIGHT_FLASH: begin
                main_nx = flash_nx ? YEL : OFF;
                side_nx = flash_nx ? YEL : OFF;
            end
            default: begin
                main_nx = RED;
                side_nx = RED;
            end
        endcase
    end

    // Controller registers; reset drops straight back to main green without clearance phases
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MAIN_GREEN;
            grant       <= GRANT_SIDE;
            last_served <= GRANT_PED;
            timer       <= '0;
            flash       <= 1'b0;
            side_pend   <= 1'b0;
            ped_pend    <= 1'b0;
            main_lamp   <= GRN;
            side_lamp   <= RED;
            ped_walk    <= 1'b0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            last_served <= last_served_nx;
            timer       <= timer_nx;
            flash       <= flash_nx;
            side_pend   <= side_pend_nx;
            ped_pend    <= ped_pend_nx;
            main_lamp   <= main_nx;
            side_lamp   <= side_nx;
            ped_walk    <= walk_nx;
        end
    end

    assign ped_wait = ped_pend;
    assign state_o  = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int DIV = 4;

    typedef struct {
        state_t     st;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       wt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       ped_walk;
    logic       ped_wait;
    logic [3:0] state_o;

    int    vectors = 0;
    int    miscompares = 0;
    int    tick_no = 0;
    string scen = "";
    exp_t  sb[$];

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .TICK_DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .night_mode(night_mode),
        .main_lamp (main_lamp),
        .side_lamp (side_lamp),
        .ped_walk  (ped_walk),
        .ped_wait  (ped_wait),
        .state_o   (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One expected sample per tick of dwell; flashing phases start with flash=0
    function automatic void push_phase(input state_t st, input int n, input logic wt);
        exp_t e;
        logic fl;
        for (int i = 0; i < n; i++) begin
            fl   = i[0];
            e.st = st;
            e.wt = wt;
            e.w  = 1'b0;
            e.m  = RED;
            e.s  = RED;
            case (st)
                MAIN_GREEN:  e.m = GRN;
                MAIN_YELLOW: e.m = YEL;
                SIDE_GREEN:  e.s = GRN;
                SIDE_YELLOW: e.s = YEL;
                PED_WALK:    e.w = 1'b1;
                PED_CLEAR:   e.w = fl;
                NIGHT_FLASH: begin
                    e.m = fl ? YEL : OFF;
                    e.s = fl ? YEL : OFF;
                end
                default: ;
            endcase
            sb.push_back(e);
        end
    endfunction

    task automatic check_sample();
        exp_t  e;
        string t;
        t = $sformatf("%s_t%0d", scen, tick_no);
        check({t, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({t, "_state"}, 32'(state_o), 32'(e.st));
            check({t, "_main"}, 32'(main_lamp), 32'(e.m));
            check({t, "_side"}, 32'(side_lamp), 32'(e.s));
            check({t, "_walk"}, 32'(ped_walk), 32'(e.w));
            check({t, "_wait"}, 32'(ped_wait), 32'(e.wt));
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick_no = 0;
    endtask

    task automatic step_tick();
        repeat (DIV) @(posedge clk);
        #1;
        tick_no++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            step_tick();
            check_sample();
        end
    endtask

    task automatic pulse_side();
        side_req = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 side_req = 1'b0;
            end
        join_none
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 ped_req = 1'b0;
            end
        join_none
    endtask

    initial begin
        // Idle hold: reset state, then 100 ticks of main green with no requests
        scen = "idle";
        reset_dut();
        push_phase(MAIN_GREEN, 101, 1'b0);
        check_sample();
        run_ticks(100);

        // Side service from a single-cycle sensor pulse
        scen = "side";
        reset_dut();
        push_phase(MAIN_GREEN, 10, 1'b0);
        push_phase(MAIN_YELLOW, 3, 1'b0);
        push_phase(ALL_RED_GO, 1, 1'b0);
        push_phase(SIDE_GREEN, 8, 1'b0);
        push_phase(SIDE_YELLOW, 3, 1'b0);
        push_phase(ALL_RED_RET, 1, 1'b0);
        push_phase(MAIN_GREEN, 3, 1'b0);
        check_sample();
        run_ticks(2);
        pulse_side();
        run_ticks(26);

        // Arbitration: both requests held from reset, side wins first, then pedestrians
        scen = "arb";
        side_req = 1'b1;
        ped_req  = 1'b1;
        reset_dut();
        push_phase(MAIN_GREEN, 1, 1'b0);
        push_phase(MAIN_GREEN, 9, 1'b1);
        push_phase(MAIN_YELLOW, 3, 1'b1);
        push_phase(ALL_RED_GO, 1, 1'b1);
        push_phase(SIDE_GREEN, 8, 1'b1);
        push_phase(SIDE_YELLOW, 3, 1'b1);
        push_phase(ALL_RED_RET, 1, 1'b1);
        push_phase(MAIN_GREEN, 10, 1'b1);
        push_phase(MAIN_YELLOW, 3, 1'b1);
        push_phase(ALL_RED_GO, 1, 1'b1);
        push_phase(PED_WALK, 6, 1'b0);
        push_phase(PED_CLEAR, 3, 1'b0);
        push_phase(ALL_RED_RET, 1, 1'b0);
        push_phase(MAIN_GREEN, 2, 1'b0);
        check_sample();
        run_ticks(14);
        side_req = 1'b0;
        ped_req  = 1'b0;
        run_ticks(37);

        // Night mode raised mid side-green, pedestrian press ignored while flashing
        scen = "night";
        reset_dut();
        push_phase(MAIN_GREEN, 10, 1'b0);
        push_phase(MAIN_YELLOW, 3, 1'b0);
        push_phase(ALL_RED_GO, 1, 1'b0);
        push_phase(SIDE_GREEN, 8, 1'b0);
        push_phase(SIDE_YELLOW, 3, 1'b0);
        push_phase(ALL_RED_RET, 1, 1'b0);
        push_phase(MAIN_GREEN, 10, 1'b0);
        push_phase(MAIN_YELLOW, 3, 1'b0);
        push_phase(ALL_RED_GO, 1, 1'b0);
        push_phase(NIGHT_FLASH, 6, 1'b0);
        push_phase(ALL_RED_RET, 1, 1'b0);
        push_phase(MAIN_GREEN, 4, 1'b0);
        check_sample();
        run_ticks(2);
        pulse_side();
        run_ticks(14);
        night_mode = 1'b1;
        run_ticks(26);
        pulse_ped();
        run_ticks(3);
        night_mode = 1'b0;
        run_ticks(5);

        // Reset pulsed during the walk phase aborts straight to main green
        scen = "abort";
        reset_dut();
        push_phase(MAIN_GREEN, 3, 1'b0);
        push_phase(MAIN_GREEN, 7, 1'b1);
        push_phase(MAIN_YELLOW, 3, 1'b1);
        push_phase(ALL_RED_GO, 1, 1'b1);
        push_phase(PED_WALK, 3, 1'b0);
        check_sample();
        run_ticks(2);
        pulse_ped();
        run_ticks(14);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick_no = 0;
        push_phase(MAIN_GREEN, 6, 1'b0);
        check_sample();
        run_ticks(5);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
